// File: rtl/divisor_secuencial_if.sv
// ----------------------------------------------------------------------------
// divisor_secuencial_if
// Handshake and data bundle between the ALU and the sequential divider.
//   start  : request a division (driven by the ALU)
//   A, B   : dividend / divisor, sampled with start (driven by the ALU)
//   Q, Rm  : quotient / remainder of the last result (driven by the divider)
//   busy   : division in progress
//   done   : one-cycle pulse, Q/Rm/dz valid
//   dz     : divide-by-zero flag for the last result
// Modports: master = ALU side, slave = divider side.
// ----------------------------------------------------------------------------
interface divisor_secuencial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Rm;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output start, A, B,
        input  Q, Rm, busy, done, dz
    );

    modport slave (
        input  start, A, B,
        output Q, Rm, busy, done, dz
    );
endinterface

// File: rtl/divisor_secuencial.sv
// ----------------------------------------------------------------------------
// divisor_secuencial
// Multi-cycle unsigned restoring divider. One trial subtraction per clock,
// MSB first. A subtract that borrows restores the partial remainder; one
// that does not keeps the difference and shifts a 1 into the quotient.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : divisor_secuencial_if.slave (start, A, B, Q, Rm, busy, done, dz)
//
// Parameters:
//   WIDTH : operand/quotient/remainder width in bits (>= 2)
//
// Build option:
//   DIV_EARLY_EXIT_EN : when defined, a start with A < B (B != 0) completes in
//                       one cycle (Q=0, Rm=A) without entering CALC.
// ----------------------------------------------------------------------------
module divisor_secuencial #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    divisor_secuencial_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend;   // shifts left, MSB feeds the trial value
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;       // quotient bits enter at the LSB
    // Partial remainder. After every step P < divisor, so its WIDTH+1-th bit
    // is always zero and only the low WIDTH bits need storing.
    logic [WIDTH-1:0] part;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] p_next;

    // WIDTH+1-bit subtractor stage; diff[WIDTH] is the borrow.
    // NOTE: every combinational output gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        trial  = {part, dividend[WIDTH-1]};
        diff   = trial - {1'b0, divisor};
        q_bit  = ~diff[WIDTH];
        p_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            quot     <= '0;
            part     <= '0;
            count    <= '0;
            bus.Q    <= '0;
            bus.Rm   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.B == '0) begin
                            state    <= DONE;
                            bus.Q    <= '1;
                            bus.Rm   <= bus.A;
                            bus.dz   <= 1'b1;
                            bus.done <= 1'b1;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (bus.A < bus.B) begin
                            state    <= DONE;
                            bus.Q    <= '0;
                            bus.Rm   <= bus.A;
                            bus.dz   <= 1'b0;
                            bus.done <= 1'b1;
                        end
`endif
                        else begin
                            state    <= CALC;
                            dividend <= bus.A;
                            divisor  <= bus.B;
                            part     <= '0;
                            quot     <= '0;
                            count    <= CW'(WIDTH);
                            bus.dz   <= 1'b0;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                // start/A/B are not looked at here, so requests during CALC
                // are ignored.
                CALC: begin
                    part     <= p_next;
                    quot     <= {quot[WIDTH-2:0], q_bit};
                    dividend <= dividend << 1;
                    count    <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.Q    <= {quot[WIDTH-2:0], q_bit};
                        bus.Rm   <= p_next;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_secuencial.sv
// ----------------------------------------------------------------------------
// tb_divisor_secuencial
// Directed bench for divisor_secuencial with WIDTH=4. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// ----------------------------------------------------------------------------
module tb_divisor_secuencial;
    localparam int WIDTH   = 4;
    localparam int MAX_CYC = 40;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    divisor_secuencial_if #(.WIDTH(WIDTH)) bus ();

    divisor_secuencial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a request at the current (falling-edge) time and drop it one
    // cycle later; the rising edge in between is the start edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called one cycle after the start edge. Returns the cycle (1-based) in
    // which done is seen, 0 if it never comes, and how many cycles busy was
    // high before it. Leaves time at the falling edge of the done cycle.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        for (int i = 1; i <= MAX_CYC; i++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        issue(a, b);
        wait_done(lat, busy_cyc);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Q !== 4'd0 || bus.Rm !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got Q=%0d Rm=%0d busy=%b done=%b dz=%b, want all 0",
                     bus.Q, bus.Rm, bus.busy, bus.done, bus.dz);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(4'd13, 4'd3, lat, bc);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d, want 5", lat); end
        checks++;
        if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d, want 4", bc); end
        checks++;
        if (bus.Q !== 4'd4 || bus.Rm !== 4'd1 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_13_div_3: got Q=%0d Rm=%0d dz=%b, want Q=4 Rm=1 dz=0", bus.Q, bus.Rm, bus.dz);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got done=%b after pulse, want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(4'd15, 4'd1, lat, bc);
        checks++;
        if (lat !== 5 || bus.Q !== 4'd15 || bus.Rm !== 4'd0) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d Q=%0d Rm=%0d, want lat=5 Q=15 Rm=0", lat, bus.Q, bus.Rm);
        end
        // Still inside the done cycle: request the next division now.
        issue(4'd9, 4'd4);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got busy=%b right after done, want 1", bus.busy); end
        wait_done(lat, bc);
        checks++;
        if (lat !== 5 || bus.Q !== 4'd2 || bus.Rm !== 4'd1 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d Q=%0d Rm=%0d dz=%b, want lat=5 Q=2 Rm=1 dz=0",
                     lat, bus.Q, bus.Rm, bus.dz);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(4'd7, 4'd0, lat, bc);
        checks++;
        if (lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL dz_timing: got lat=%0d busy_cycles=%0d, want lat=1 busy_cycles=0", lat, bc);
        end
        checks++;
        if (bus.Q !== 4'd15 || bus.Rm !== 4'd7 || bus.dz !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got Q=%0d Rm=%0d dz=%b, want Q=15 Rm=7 dz=1", bus.Q, bus.Rm, bus.dz);
        end
        @(negedge clk);
        checks++;
        if (bus.dz !== 1'b1 || bus.Q !== 4'd15) begin
            errors++;
            $display("FAIL dz_hold: got Q=%0d dz=%b while idle, want Q=15 dz=1", bus.Q, bus.dz);
        end
        issue(4'd6, 4'd2);
        checks++;
        if (bus.dz !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start: got dz=%b, want 0", bus.dz); end
        wait_done(lat, bc);
        checks++;
        if (lat !== 5 || bus.Q !== 4'd3 || bus.Rm !== 4'd0 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL dz_followup: got lat=%0d Q=%0d Rm=%0d dz=%b, want lat=5 Q=3 Rm=0 dz=0",
                     lat, bus.Q, bus.Rm, bus.dz);
        end
    endtask

    task automatic test_small_dividend();
        int lat, bc;
        int exp_lat, exp_bc;
        exp_lat = EARLY ? 1 : 5;
        exp_bc  = EARLY ? 0 : 4;
        run_op(4'd2, 4'd9, lat, bc);
        checks++;
        if (lat !== exp_lat || bc !== exp_bc) begin
            errors++;
            $display("FAIL small_timing: got lat=%0d busy_cycles=%0d, want lat=%0d busy_cycles=%0d",
                     lat, bc, exp_lat, exp_bc);
        end
        checks++;
        if (bus.Q !== 4'd0 || bus.Rm !== 4'd2 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL small_result: got Q=%0d Rm=%0d dz=%b, want Q=0 Rm=2 dz=0", bus.Q, bus.Rm, bus.dz);
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        logic [WIDTH-1:0] q_seen, r_seen;
        pulses = 0;
        q_seen = '0;
        r_seen = '0;
        @(negedge clk);
        issue(4'd12, 4'd5);
        @(negedge clk);
        // Second CALC cycle: a competing request with different operands.
        issue(4'd1, 4'd1);
        bus.A = 4'd3;
        bus.B = 4'd3;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                pulses++;
                q_seen = bus.Q;
                r_seen = bus.Rm;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_pulse_count: got %0d done pulses, want 1", pulses); end
        checks++;
        if (q_seen !== 4'd2 || r_seen !== 4'd2) begin
            errors++;
            $display("FAIL ignore_result: got Q=%0d Rm=%0d, want Q=2 Rm=2", q_seen, r_seen);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        pulses = 0;
        @(negedge clk);
        issue(4'd14, 4'd3);
        @(negedge clk);
        // Mid second CALC cycle, away from any clock edge.
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 4'd0 || bus.Rm !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got Q=%0d Rm=%0d busy=%b done=%b dz=%b, want all 0",
                     bus.Q, bus.Rm, bus.busy, bus.done, bus.dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d cycles with busy/done after release, want 0", pulses);
        end
    endtask

    task automatic test_sweep();
        int lat, bc, exp_lat;
        int bad;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(WIDTH'(a), WIDTH'(b), lat, bc);
                if (b == 0)             exp_lat = 1;
                else if (EARLY && a < b) exp_lat = 1;
                else                    exp_lat = 5;
                checks++;
                if (lat !== exp_lat) begin
                    errors++; bad++;
                    $display("FAIL sweep_latency a=%0d b=%0d: got %0d, want %0d", a, b, lat, exp_lat);
                end
                if (b == 0) begin
                    checks++;
                    if (bus.dz !== 1'b1 || bus.Q !== 4'd15 || bus.Rm !== WIDTH'(a)) begin
                        errors++; bad++;
                        $display("FAIL sweep_dz a=%0d: got Q=%0d Rm=%0d dz=%b, want Q=15 Rm=%0d dz=1",
                                 a, bus.Q, bus.Rm, bus.dz, a);
                    end
                end else begin
                    checks++;
                    if (bus.dz !== 1'b0 || int'(bus.Q) * b + int'(bus.Rm) != a || int'(bus.Rm) >= b) begin
                        errors++; bad++;
                        $display("FAIL sweep_invariant a=%0d b=%0d: got Q=%0d Rm=%0d dz=%b, want Q=%0d Rm=%0d dz=0",
                                 a, b, bus.Q, bus.Rm, bus.dz, a / b, a % b);
                    end
                end
                if (bad > 10) return;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_small_dividend();
        test_start_while_busy();
        test_async_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
